pipelined_cpu_fwd: RTL and testbench

Parametrised five-stage (IF/ID/EX/MEM/WB) MIPS-subset core that succeeds the first-generation pipeline. Adds hazard handling:
- operand forwarding,
- load-use interlock,
- branch/jump flush,
- a stall-only mode selectable by parameter.

It has generic data width, internal instruction/data memories sized by parameter, an instruction-load port, and retire/debug outputs for verification.

---
 rtl/pipelined_cpu_fwd_if.sv | 28 ++
 rtl/pipelined_cpu_fwd.sv | 246 ++++++++++++++++++++++++
 tb/tb_pipelined_cpu_fwd.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cpu_fwd_if.sv
// Run control, instruction-load port and retire/debug observation bus of pipelined_cpu_fwd.
interface pipelined_cpu_fwd_if #(
  parameter int DATA_W     = 32,
  parameter int IMEM_WORDS = 64
);
  localparam int IAW = $clog2(IMEM_WORDS);

  logic              run;
  logic              imem_we;
  logic [IAW-1:0]    imem_waddr;
  logic [31:0]       imem_wdata;
  logic              wb_valid;
  logic [4:0]        wb_wn;
  logic [DATA_W-1:0] wb_wd;
  logic [DATA_W-1:0] pc_out;
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  modport master (
    output run, imem_we, imem_waddr, imem_wdata,
    input  wb_valid, wb_wn, wb_wd, pc_out, stall_cnt, flush_cnt
  );

  modport slave (
    input  run, imem_we, imem_waddr, imem_wdata,
    output wb_valid, wb_wn, wb_wd, pc_out, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipelined_cpu_fwd.sv
// Five-stage MIPS-subset core with operand forwarding, load-use/interlock stalls
// and branch/jump flushing; FORWARD_EN=0 falls back to stalling until WB.
module pipelined_cpu_fwd #(
  parameter int DATA_W     = 32,
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64,
  parameter bit FORWARD_EN = 1'b1
) (
  input logic clk,
  input logic reset,
  pipelined_cpu_fwd_if.slave bus
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [DATA_W-1:0] FOUR = DATA_W'(4);
  localparam logic [DATA_W-1:0] J_KEEP_MASK = ~DATA_W'(32'h0FFF_FFFF);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  logic [31:0]       imem [IMEM_WORDS];
  logic [DATA_W-1:0] dmem [DMEM_WORDS];
  logic [DATA_W-1:0] rf   [32];

  logic [DATA_W-1:0] pc, ifid_pc4;
  logic [31:0]       ifid_instr;

  ctrl_t             idex_ctrl;
  logic [4:0]        idex_rs, idex_rt, idex_wn;
  logic [DATA_W-1:0] idex_a, idex_b, idex_imm, idex_pc4;

  logic              exmem_rw, exmem_mr, exmem_mw;
  logic [4:0]        exmem_wn;
  logic [DATA_W-1:0] exmem_alu, exmem_sd;

  logic              memwb_rw;
  logic [4:0]        memwb_wn;
  logic [DATA_W-1:0] memwb_wd;

  logic [15:0] stall_cnt, flush_cnt;

  logic [4:0]        id_rs, id_rt, id_rd, id_wn;
  ctrl_t             id_ctrl;
  logic              uses_rs, uses_rt, is_j, stall, ld_hz, il_hz, wb_we;
  logic [DATA_W-1:0] id_a, id_b, id_imm, jump_target;
  logic [31:0]       jump_lo;
  logic [DATA_W-1:0] fwd_a, fwd_b, ex_a, ex_b, alu_b, alu_res, br_target, mem_wd;
  logic              taken;

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {15'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign wb_we = memwb_rw && (memwb_wn != 5'd0);
  assign id_rs = ifid_instr[25:21];
  assign id_rt = ifid_instr[20:16];
  assign id_rd = ifid_instr[15:11];

  always_comb begin
    id_ctrl = '0;
    id_wn   = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_j    = 1'b0;
    case (ifid_instr[31:26])
      6'h00: begin
        id_ctrl.reg_write = 1'b1;
        id_wn   = id_rd;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        case (ifid_instr[5:0])
          6'h20: id_ctrl.alu_op = ALU_ADD;
          6'h22: id_ctrl.alu_op = ALU_SUB;
          6'h24: id_ctrl.alu_op = ALU_AND;
          6'h25: id_ctrl.alu_op = ALU_OR;
          6'h2A: id_ctrl.alu_op = ALU_SLT;
          default: begin
            id_ctrl.reg_write = 1'b0;
            id_wn   = '0;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
          end
        endcase
      end
      6'h23: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.mem_read  = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        id_wn   = id_rt;
        uses_rs = 1'b1;
      end
      6'h2B: begin
        id_ctrl.mem_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      6'h04: begin
        id_ctrl.branch = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      6'h08: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        id_wn   = id_rt;
        uses_rs = 1'b1;
      end
      6'h02: is_j = 1'b1;
      default: ;
    endcase
  end

  // Register reads are write-first so a producer in WB needs no forwarding path into ID.
  always_comb begin
    id_a = (id_rs == 5'd0) ? '0 : ((wb_we && memwb_wn == id_rs) ? memwb_wd : rf[id_rs]);
    id_b = (id_rt == 5'd0) ? '0 : ((wb_we && memwb_wn == id_rt) ? memwb_wd : rf[id_rt]);
    id_imm = DATA_W'($signed(ifid_instr[15:0]));
    jump_lo = {4'h0, ifid_instr[25:0], 2'b00};
    jump_target = (ifid_pc4 & J_KEEP_MASK) | DATA_W'(jump_lo);
    ld_hz = idex_ctrl.mem_read && (idex_wn != 5'd0) &&
            ((uses_rs && idex_wn == id_rs) || (uses_rt && idex_wn == id_rt));
    il_hz = (idex_ctrl.reg_write && (idex_wn != 5'd0) &&
             ((uses_rs && idex_wn == id_rs) || (uses_rt && idex_wn == id_rt))) ||
            (exmem_rw && (exmem_wn != 5'd0) &&
             ((uses_rs && exmem_wn == id_rs) || (uses_rt && exmem_wn == id_rt)));
    stall = FORWARD_EN ? ld_hz : il_hz;
  end

  always_comb begin
    fwd_a = idex_a;
    if (exmem_rw && exmem_wn != 5'd0 && exmem_wn == idex_rs) fwd_a = exmem_alu;
    else if (wb_we && memwb_wn == idex_rs)                   fwd_a = memwb_wd;
    fwd_b = idex_b;
    if (exmem_rw && exmem_wn != 5'd0 && exmem_wn == idex_rt) fwd_b = exmem_alu;
    else if (wb_we && memwb_wn == idex_rt)                   fwd_b = memwb_wd;
    ex_a  = FORWARD_EN ? fwd_a : idex_a;
    ex_b  = FORWARD_EN ? fwd_b : idex_b;
    alu_b = idex_ctrl.alu_src ? idex_imm : ex_b;
    alu_res = '0;
    case (idex_ctrl.alu_op)
      ALU_ADD: alu_res = ex_a + alu_b;
      ALU_SUB: alu_res = ex_a - alu_b;
      ALU_AND: alu_res = ex_a & alu_b;
      ALU_OR:  alu_res = ex_a | alu_b;
      ALU_SLT: alu_res[0] = $signed(ex_a) < $signed(alu_b);
      default: alu_res = '0;
    endcase
    taken     = idex_ctrl.branch && (ex_a == ex_b);
    br_target = idex_pc4 + (idex_imm << 2);
    mem_wd    = exmem_mr ? dmem[exmem_alu[DAW+1:2]] : exmem_alu;
  end

  // Precedence each cycle: taken branch flush, then hazard stall, then jump, then normal fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
      idex_ctrl  <= '0;
      idex_rs    <= '0;
      idex_rt    <= '0;
      idex_wn    <= '0;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_imm   <= '0;
      idex_pc4   <= '0;
      exmem_rw   <= 1'b0;
      exmem_mr   <= 1'b0;
      exmem_mw   <= 1'b0;
      exmem_wn   <= '0;
      exmem_alu  <= '0;
      exmem_sd   <= '0;
      memwb_rw   <= 1'b0;
      memwb_wn   <= '0;
      memwb_wd   <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.run) begin
      if (wb_we) rf[memwb_wn] <= memwb_wd;
      memwb_rw  <= exmem_rw;
      memwb_wn  <= exmem_wn;
      memwb_wd  <= mem_wd;
      exmem_rw  <= idex_ctrl.reg_write;
      exmem_mr  <= idex_ctrl.mem_read;
      exmem_mw  <= idex_ctrl.mem_write;
      exmem_wn  <= idex_wn;
      exmem_alu <= alu_res;
      exmem_sd  <= ex_b;
      if (taken) begin
        pc         <= br_target;
        ifid_instr <= '0;
        idex_ctrl  <= '0;
        idex_wn    <= '0;
        flush_cnt  <= sat_add(flush_cnt, 2'd2);
      end else if (stall) begin
        idex_ctrl <= '0;
        idex_wn   <= '0;
        stall_cnt <= sat_add(stall_cnt, 2'd1);
      end else begin
        idex_ctrl <= id_ctrl;
        idex_rs   <= id_rs;
        idex_rt   <= id_rt;
        idex_wn   <= id_wn;
        idex_a    <= id_a;
        idex_b    <= id_b;
        idex_imm  <= id_imm;
        idex_pc4  <= ifid_pc4;
        if (is_j) begin
          pc         <= jump_target;
          ifid_instr <= '0;
          flush_cnt  <= sat_add(flush_cnt, 2'd1);
        end else begin
          pc         <= pc + FOUR;
          ifid_instr <= imem[pc[IAW+1:2]];
          ifid_pc4   <= pc + FOUR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.imem_we) imem[bus.imem_waddr] <= bus.imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset && bus.run && exmem_mw) dmem[exmem_alu[DAW+1:2]] <= exmem_sd;
  end

  assign bus.wb_valid  = wb_we;
  assign bus.wb_wn     = memwb_wn;
  assign bus.wb_wd     = memwb_wd;
  assign bus.pc_out    = pc;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_pipelined_cpu_fwd.sv
// Directed bench running the same programs on a forwarding core and an interlock-only core.
module tb_pipelined_cpu_fwd;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [36:0] ret_f[$];
  logic [36:0] ret_i[$];
  logic [36:0] exp_q[$];
  logic [31:0] prog [8];

  always #5 clk = ~clk;

  pipelined_cpu_fwd_if #(.DATA_W(32), .IMEM_WORDS(64)) bus_f ();
  pipelined_cpu_fwd_if #(.DATA_W(32), .IMEM_WORDS(64)) bus_i ();

  pipelined_cpu_fwd #(.DATA_W(32), .IMEM_WORDS(64), .DMEM_WORDS(64), .FORWARD_EN(1'b1)) dut_f (
    .clk(clk), .reset(reset), .bus(bus_f));
  pipelined_cpu_fwd #(.DATA_W(32), .IMEM_WORDS(64), .DMEM_WORDS(64), .FORWARD_EN(1'b0)) dut_i (
    .clk(clk), .reset(reset), .bus(bus_i));

  function automatic logic [31:0] addi(input int rt, input int rs, input int imm);
    return {6'h08, rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] rtype(input int rd, input int rs, input int rt, input int fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction
  function automatic logic [31:0] itype(input int op, input int rt, input int rs, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] jmp(input int word);
    return {6'h02, word[25:0]};
  endfunction
  function automatic logic [36:0] ret(input int wn, input int wd);
    return {wn[4:0], wd[31:0]};
  endfunction

  task automatic apply_stimulus(input logic r, input logic we, input logic [5:0] a, input logic [31:0] d);
    bus_f.run = r;  bus_f.imem_we = we;  bus_f.imem_waddr = a;  bus_f.imem_wdata = d;
    bus_i.run = r;  bus_i.imem_we = we;  bus_i.imem_waddr = a;  bus_i.imem_wdata = d;
  endtask

  // Retires are logged only for edges where the pipeline actually advanced.
  task automatic step();
    logic rec;
    rec = bus_f.run && !reset;
    @(posedge clk);
    #1;
    if (rec && bus_f.wb_valid) ret_f.push_back({bus_f.wb_wn, bus_f.wb_wd});
    if (rec && bus_i.wb_valid) ret_i.push_back({bus_i.wb_wn, bus_i.wb_wd});
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_retires(input string tag, input bit interlock);
    logic [36:0] q[$];
    q = interlock ? ret_i : ret_f;
    check_output($sformatf("%s_count", tag), 64'(q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      check_output($sformatf("%s_ret%0d", tag, k), (k < q.size()) ? 64'(q[k]) : 64'h1F_FFFF_FFFF, 64'(exp_q[k]));
  endtask

  task automatic load_program();
    reset = 1'b1;
    for (int a = 0; a < 64; a++) begin
      apply_stimulus(1'b0, 1'b1, 6'(a), (a < 8) ? prog[a] : 32'h0);
      step();
    end
    apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0);
    step();
  endtask

  task automatic start_program();
    load_program();
    apply_stimulus(1'b1, 1'b0, 6'd0, 32'h0);
    reset = 1'b0;
    ret_f.delete();
    ret_i.delete();
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0);

    // Empty program: no retires, PC walks by 4, frozen while run is low
    for (int a = 0; a < 8; a++) prog[a] = 32'h0;
    load_program();
    check_output("reset_pc", 64'(bus_f.pc_out), 64'd0);
    check_output("reset_wb", 64'({bus_f.wb_valid, bus_f.wb_wn, bus_f.wb_wd}), 64'd0);
    reset = 1'b0;
    steps(2);
    check_output("idle_run0_pc", 64'(bus_f.pc_out), 64'd0);
    apply_stimulus(1'b1, 1'b0, 6'd0, 32'h0);
    step();
    check_output("nop_pc4", 64'(bus_f.pc_out), 64'd4);
    step();
    check_output("nop_pc8", 64'(bus_f.pc_out), 64'd8);
    step();
    check_output("nop_pc12", 64'(bus_i.pc_out), 64'd12);
    steps(6);
    check_output("nop_retires", 64'(ret_f.size() + ret_i.size()), 64'd0);
    check_output("nop_counters", 64'({bus_f.stall_cnt, bus_f.flush_cnt}), 64'd0);

    // Back-to-back dependent ALU ops
    prog[0] = addi(1, 0, 5);
    prog[1] = rtype(2, 1, 1, 'h20);
    prog[2] = rtype(3, 2, 1, 'h22);
    start_program();
    steps(3);
    check_output("fwd_latency_idle", 64'(bus_f.wb_valid), 64'd0);
    step();
    check_output("fwd_ret1", 64'({bus_f.wb_valid, bus_f.wb_wn, bus_f.wb_wd}), {26'd0, 1'b1, 5'd1, 32'd5});
    step();
    check_output("fwd_ret2", 64'({bus_f.wb_valid, bus_f.wb_wn, bus_f.wb_wd}), {26'd0, 1'b1, 5'd2, 32'd10});
    step();
    check_output("fwd_ret3", 64'({bus_f.wb_valid, bus_f.wb_wn, bus_f.wb_wd}), {26'd0, 1'b1, 5'd3, 32'd5});
    steps(8);
    check_output("fwd_alu_stalls", 64'(bus_f.stall_cnt), 64'd0);
    check_output("ilk_alu_stalls", 64'(bus_i.stall_cnt), 64'd4);
    exp_q = '{ret(1, 5), ret(2, 10), ret(3, 5)};
    check_retires("ilk_alu", 1'b1);

    // Store, reload, and use of the loaded value
    prog[0] = addi(1, 0, 7);
    prog[1] = itype('h2B, 1, 0, 8);
    prog[2] = itype('h23, 4, 0, 8);
    prog[3] = rtype(5, 4, 4, 'h20);
    start_program();
    steps(14);
    exp_q = '{ret(1, 7), ret(4, 7), ret(5, 14)};
    check_retires("fwd_ldst", 1'b0);
    check_retires("ilk_ldst", 1'b1);
    check_output("fwd_loaduse_stalls", 64'(bus_f.stall_cnt), 64'd1);
    check_output("ilk_ldst_stalls", 64'(bus_i.stall_cnt), 64'd4);

    // Taken beq skips two instructions
    prog[0] = addi(1, 0, 1);
    prog[1] = itype('h04, 1, 1, 2);
    prog[2] = addi(6, 0, 9);
    prog[3] = addi(7, 0, 9);
    prog[4] = addi(8, 0, 3);
    start_program();
    steps(14);
    exp_q = '{ret(1, 1), ret(8, 3)};
    check_retires("fwd_beq", 1'b0);
    check_retires("ilk_beq", 1'b1);
    check_output("fwd_beq_flush", 64'(bus_f.flush_cnt), 64'd2);
    check_output("fwd_beq_stalls", 64'(bus_f.stall_cnt), 64'd0);
    check_output("ilk_beq_counts", 64'({bus_i.stall_cnt, bus_i.flush_cnt}), {32'd0, 16'd2, 16'd2});

    // Jump over one instruction
    for (int a = 0; a < 8; a++) prog[a] = 32'h0;
    prog[0] = jmp(4);
    prog[1] = addi(9, 0, 1);
    prog[4] = addi(10, 0, 2);
    start_program();
    step();
    check_output("j_pc_before", 64'(bus_f.pc_out), 64'd4);
    step();
    check_output("j_pc_target", 64'(bus_f.pc_out), 64'd16);
    steps(12);
    exp_q = '{ret(10, 2)};
    check_retires("fwd_j", 1'b0);
    check_output("fwd_j_flush", 64'(bus_f.flush_cnt), 64'd1);
    check_output("ilk_j_flush", 64'(bus_i.flush_cnt), 64'd1);

    // Pause with run low, then reset mid-program
    prog[0] = addi(1, 0, 1);
    prog[1] = addi(2, 0, 2);
    prog[2] = rtype(3, 1, 2, 'h20);
    prog[3] = addi(4, 0, 4);
    prog[4] = rtype(5, 3, 4, 'h20);
    start_program();
    steps(5);
    apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_output($sformatf("freeze_pc%0d", k), 64'(bus_f.pc_out), 64'd20);
      check_output($sformatf("freeze_wb%0d", k), 64'({bus_f.wb_valid, bus_f.wb_wn, bus_f.wb_wd}),
                   {26'd0, 1'b1, 5'd2, 32'd2});
    end
    apply_stimulus(1'b1, 1'b0, 6'd0, 32'h0);
    steps(10);
    exp_q = '{ret(1, 1), ret(2, 2), ret(3, 3), ret(4, 4), ret(5, 7)};
    check_retires("fwd_pause", 1'b0);
    check_retires("ilk_pause", 1'b1);
    steps(2);
    reset = 1'b1;
    step();
    check_output("midreset_pc", 64'(bus_f.pc_out), 64'd0);
    check_output("midreset_wb", 64'({bus_f.wb_valid, bus_f.wb_wn, bus_f.wb_wd}), 64'd0);
    check_output("midreset_cnt", 64'({bus_i.stall_cnt, bus_i.flush_cnt}), 64'd0);
    reset = 1'b0;
    ret_f.delete();
    ret_i.delete();
    steps(3);
    check_output("restart_idle", 64'(bus_f.wb_valid), 64'd0);
    step();
    check_output("restart_ret1", 64'({bus_f.wb_valid, bus_f.wb_wn, bus_f.wb_wd}), {26'd0, 1'b1, 5'd1, 32'd1});
    steps(8);
    check_retires("fwd_restart", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
